// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Increment an index, wrapping back to 0 at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating-base priority picker: first set req bit at or above
// base_i, wrapping from N-1 back to 0.
module arb_pick #(
    parameter  int unsigned N    = 2,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] base_i,
    output logic [N-1:0]    onehot_c,
    output logic [IDXW-1:0] idx_c,
    output logic            valid_c
);

    // Walk the request vector from base_i and stop at the first hit.
    always_comb begin
        int unsigned j;
        onehot_c = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(base_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_c && req_i[j]) begin
                valid_c     = 1'b1;
                onehot_c[j] = 1'b1;
                idx_c       = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter: registered one-hot grant held until the owner's done
// pulse or a watchdog timeout, with back-to-back re-arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS    = 2,
    parameter  int unsigned ARB_MODE       = 0,
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDXW           = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDXW-1:0]        grant_idx,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [IDXW-1:0]        err_idx
);

    // Counter is sized for TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic          WD_EN   = (TIMEOUT_CYCLES > 0);

    arb_state_e             state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [IDXW-1:0]        grant_idx_q, grant_idx_d;
    logic [IDXW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]          wdog_q, wdog_d;
    logic                   terr_q, terr_d;
    logic [IDXW-1:0]        err_idx_q, err_idx_d;

    logic [IDXW-1:0]        pick_base;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic [IDXW-1:0]        pick_idx;
    logic                   pick_valid;
    logic                   done_hit;
    logic                   wd_expire;
    logic                   arbitrate;

    // Fixed priority always searches from client 0.
    assign pick_base = (ARB_MODE == ARB_RR) ? ptr_q : '0;

    arb_pick #(
        .N(NUM_CLIENTS)
    ) u_pick (
        .req_i    (req),
        .base_i   (pick_base),
        .onehot_c (pick_onehot),
        .idx_c    (pick_idx),
        .valid_c  (pick_valid)
    );

    // Only the current owner's done bit ends a grant.
    assign done_hit  = |(done & grant_q);
    assign wd_expire = WD_EN && (wdog_q == WD_LAST);

    // Next-state: grant ownership, pointer, watchdog and error capture.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        wdog_d      = wdog_q;
        terr_d      = 1'b0;
        err_idx_d   = err_idx_q;
        arbitrate   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                arbitrate = 1'b1;
            end
            ARB_GRANT: begin
                if (done_hit) begin
                    arbitrate = 1'b1;
                end else if (wd_expire) begin
                    arbitrate = 1'b1;
                    terr_d    = 1'b1;
                    err_idx_d = grant_idx_q;
                end else if (WD_EN) begin
                    wdog_d = wdog_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase

        if (arbitrate) begin
            wdog_d = '0;
            if (pick_valid) begin
                state_d     = ARB_GRANT;
                grant_d     = pick_onehot;
                grant_idx_d = pick_idx;
                ptr_d       = IDXW'(wrap_inc(32'(pick_idx), NUM_CLIENTS));
            end else begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            wdog_q      <= '0;
            terr_q      <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
            terr_q      <= terr_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign busy        = (state_q == ARB_GRANT);
    assign timeout_err = terr_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority, round-robin, watchdog and
// reset behaviour on three parameterisations sharing one clock and reset.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    // Default parameters: 2 clients, fixed priority, 64-cycle watchdog.
    logic [1:0] f_req, f_done, f_grant;
    logic [0:0] f_idx, f_eidx;
    logic       f_busy, f_terr;

    // Round-robin, 4 clients.
    logic [3:0] r_req, r_done, r_grant;
    logic [1:0] r_idx, r_eidx;
    logic       r_busy, r_terr;

    // Fixed priority, 2 clients, 8-cycle watchdog.
    logic [1:0] w_req, w_done, w_grant;
    logic [0:0] w_idx, w_eidx;
    logic       w_busy, w_terr;

    int checks = 0;
    int errors = 0;

    mem_arbiter u_fix (
        .clk(clk), .rst(rst), .req(f_req), .done(f_done), .grant(f_grant),
        .grant_idx(f_idx), .busy(f_busy), .timeout_err(f_terr), .err_idx(f_eidx)
    );

    mem_arbiter #(.NUM_CLIENTS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(64)) u_rr (
        .clk(clk), .rst(rst), .req(r_req), .done(r_done), .grant(r_grant),
        .grant_idx(r_idx), .busy(r_busy), .timeout_err(r_terr), .err_idx(r_eidx)
    );

    mem_arbiter #(.NUM_CLIENTS(2), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_wd (
        .clk(clk), .rst(rst), .req(w_req), .done(w_done), .grant(w_grant),
        .grant_idx(w_idx), .busy(w_busy), .timeout_err(w_terr), .err_idx(w_eidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq[5];
        rr_seq = '{0, 1, 2, 3, 0};

        rst = 1'b0;
        f_req = '0; f_done = '0;
        r_req = '0; r_done = '0;
        w_req = '0; w_done = '0;

        // Reset values.
        step(); step();
        chk("rst_f_grant", 32'(f_grant), 32'h0);
        chk("rst_f_busy",  32'(f_busy),  32'h0);
        chk("rst_f_idx",   32'(f_idx),   32'h0);
        chk("rst_f_terr",  32'(f_terr),  32'h0);
        chk("rst_f_eidx",  32'(f_eidx),  32'h0);
        chk("rst_r_grant", 32'(r_grant), 32'h0);
        chk("rst_w_busy",  32'(w_busy),  32'h0);
        rst = 1'b1;
        step();

        // Fixed priority: both request, client 0 wins and re-wins.
        f_req = 2'b11;
        step();
        chk("fix_first_grant", 32'(f_grant), 32'h1);
        chk("fix_first_busy",  32'(f_busy),  32'h1);
        chk("fix_first_idx",   32'(f_idx),   32'h0);
        f_done = 2'b01;
        step();
        chk("fix_rewin_grant", 32'(f_grant), 32'h1);
        f_req = 2'b10; f_done = 2'b01;
        step();
        chk("fix_handoff_grant", 32'(f_grant), 32'h2);
        chk("fix_handoff_idx",   32'(f_idx),   32'h1);
        chk("fix_handoff_busy",  32'(f_busy),  32'h1);
        // Stray done from the non-owner is ignored.
        f_done = 2'b01;
        step();
        chk("fix_stray_grant", 32'(f_grant), 32'h2);
        f_req = 2'b00; f_done = 2'b10;
        step();
        chk("fix_idle_grant", 32'(f_grant), 32'h0);
        chk("fix_idle_busy",  32'(f_busy),  32'h0);
        // Done while idle is ignored.
        f_done = 2'b11;
        step();
        chk("fix_idle_done_grant", 32'(f_grant), 32'h0);
        chk("fix_idle_done_busy",  32'(f_busy),  32'h0);
        chk("fix_no_terr",         32'(f_terr),  32'h0);
        f_done = 2'b00;

        // Round-robin, 3-cycle grants, no idle gaps.
        r_req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_idx_%0d", i),   32'(r_idx),   32'(rr_seq[i]));
            chk($sformatf("rr_grant_%0d", i), 32'(r_grant), 32'(1) << rr_seq[i]);
            chk($sformatf("rr_busy_%0d", i),  32'(r_busy),  32'h1);
            r_done = 4'b0000;
            if (i < 4) begin
                step();
                chk($sformatf("rr_hold_%0d", i), 32'(r_idx), 32'(rr_seq[i]));
                step();
                r_done = 4'(1 << rr_seq[i]);
                step();
            end
        end
        r_req = 4'b0000; r_done = 4'b0001;
        step();
        r_done = 4'b0000;
        chk("rr_end_busy", 32'(r_busy), 32'h0);

        // Watchdog: req dropped mid-grant, grant held exactly 8 cycles.
        w_req = 2'b10;
        step();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("wd_hold_grant_%0d", k), 32'(w_grant), 32'h2);
            chk($sformatf("wd_hold_terr_%0d", k),  32'(w_terr),  32'h0);
            if (k == 3) w_req = 2'b00;
            if (k < 8) step();
        end
        step();
        chk("wd_drop_grant", 32'(w_grant), 32'h0);
        chk("wd_drop_busy",  32'(w_busy),  32'h0);
        chk("wd_drop_terr",  32'(w_terr),  32'h1);
        chk("wd_drop_eidx",  32'(w_eidx),  32'h1);
        step();
        chk("wd_terr_pulse", 32'(w_terr), 32'h0);
        chk("wd_eidx_held",  32'(w_eidx), 32'h1);

        // Done coinciding with the timeout cycle wins.
        w_req = 2'b01;
        step();
        for (int k = 1; k < 8; k++) step();
        chk("wd_tie_pre_grant", 32'(w_grant), 32'h1);
        w_done = 2'b01; w_req = 2'b00;
        step();
        w_done = 2'b00;
        chk("wd_tie_grant", 32'(w_grant), 32'h0);
        chk("wd_tie_terr",  32'(w_terr),  32'h0);
        chk("wd_tie_eidx",  32'(w_eidx),  32'h1);

        // Timed-out client with req still high is granted again.
        w_req = 2'b01;
        step();
        for (int k = 1; k < 8; k++) step();
        step();
        chk("wd_regrant_grant", 32'(w_grant), 32'h1);
        chk("wd_regrant_terr",  32'(w_terr),  32'h1);
        chk("wd_regrant_eidx",  32'(w_eidx),  32'h0);
        w_req = 2'b00; w_done = 2'b01;
        step();
        w_done = 2'b00;
        chk("wd_regrant_end", 32'(w_busy), 32'h0);

        // Reset mid-grant clears immediately; pointer restarts at 0.
        r_req = 4'b0100;
        step();
        chk("rst_mid_pre_idx", 32'(r_idx), 32'h2);
        rst = 1'b0; r_req = 4'b0000;
        #1;
        chk("rst_mid_grant", 32'(r_grant), 32'h0);
        chk("rst_mid_busy",  32'(r_busy),  32'h0);
        step();
        rst = 1'b1;
        r_req = 4'b1001;
        step();
        chk("rst_ptr0_idx", 32'(r_idx), 32'h0);
        r_done = 4'b0001;
        step();
        r_done = 4'b0000;
        chk("rst_ptr_next_idx", 32'(r_idx), 32'h3);
        r_req = 4'b1000;
        step();
        chk("rst_hold3_idx", 32'(r_idx), 32'h3);
        r_req = 4'b0000; r_done = 4'b1000;
        step();
        r_done = 4'b0000;
        chk("rst_end_busy", 32'(r_busy), 32'h0);

        // Random soak: grant one-hot or zero, consistent with busy/index.
        for (int c = 0; c < 300; c++) begin
            r_req  = 4'($urandom_range(0, 15));
            r_done = 4'($urandom_range(0, 15));
            step();
            chk("soak_onehot", 32'($onehot0(r_grant)), 32'h1);
            chk("soak_busy",   32'(r_busy), 32'(|r_grant));
            if (r_busy) chk("soak_idx", 32'(r_grant), 32'(1) << r_idx);
        end
        r_req = '0; r_done = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
